// File: rtl/dedicated_pkg.sv
// Shared definitions for the dedicated-processor counter examples:
// controller state encoding and datapath source-select codes.
package dedicated_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OUT,
        S_CHECK,
        S_DEC,
        S_DONE
    } stateT;

    // Register A source select: load the start value or take A-1.
    localparam logic ASRC_LOAD = 1'b0;
    localparam logic ASRC_DEC  = 1'b1;

endpackage

// File: rtl/dedicated_countdown_dp.sv
// Down-counter datapath: register A with load/decrement source mux,
// zero comparator, and the registered output buffer with its valid strobe.
module dedicated_countdown_dp
    import dedicated_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             aSrcSel,
    input  logic             aLoad,
    input  logic             outBufSel,
    output logic             aEq0,
    output logic [WIDTH-1:0] outBuf,
    output logic             outValid
);

    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] aNext;

    // The controller only selects the decrement when A is non-zero,
    // so the plain WIDTH-bit subtraction never wraps.
    assign aNext = (aSrcSel == ASRC_DEC) ? regA - WIDTH'(1) : loadVal;
    assign aEq0  = (regA == '0);

    // NOTE: registers update with <= so every flop samples pre-edge values;
    // blocking assignments here would make results depend on statement order.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            regA <= '0;
        end else if (aLoad) begin
            regA <= aNext;
        end
    end

    // oOut holds its last value between loads; valid marks each new load.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            outBuf   <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= outBufSel;
            if (outBufSel) begin
                outBuf <= regA;
            end
        end
    end

endmodule

// File: rtl/dedicated_countdown.sv
// Dedicated-processor down-counter: controller FSM driving the countdown
// datapath; emits N..0 with one valid pulse each, then a done pulse.
module dedicated_countdown
    import dedicated_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iLoadVal,
    input  logic             iHold,
    output logic [WIDTH-1:0] oOut,
    output logic             oValid,
    output logic             oBusy,
    output logic             oDone
);

    stateT state;
    stateT stateNext;

    logic aSrcSel;
    logic aLoad;
    logic outBufSel;
    logic aEq0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        stateNext = state;
        aSrcSel   = ASRC_LOAD;
        aLoad     = 1'b0;
        outBufSel = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (iStart) begin
                    stateNext = S_LOAD;
                end
            end
            S_LOAD: begin
                aSrcSel   = ASRC_LOAD;
                aLoad     = 1'b1;
                stateNext = S_OUT;
            end
            S_OUT: begin
                if (!iHold) begin
                    outBufSel = 1'b1;
                    stateNext = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!iHold) begin
                    stateNext = aEq0 ? S_DONE : S_DEC;
                end
            end
            S_DEC: begin
                if (!iHold) begin
                    aSrcSel   = ASRC_DEC;
                    aLoad     = 1'b1;
                    stateNext = S_OUT;
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // Done is registered so it lands on the same edge that returns to idle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDone <= 1'b0;
        end else begin
            oDone <= (state == S_DONE);
        end
    end

    assign oBusy = (state != S_IDLE);

    dedicated_countdown_dp #(
        .WIDTH(WIDTH)
    ) uDp (
        .iClk     (iClk),
        .iRst     (iRst),
        .loadVal  (iLoadVal),
        .aSrcSel  (aSrcSel),
        .aLoad    (aLoad),
        .outBufSel(outBufSel),
        .aEq0     (aEq0),
        .outBuf   (oOut),
        .outValid (oValid)
    );

endmodule

// File: tb/tb_dedicated_countdown.sv
// Scoreboard bench for dedicated_countdown: expected values are queued when a
// run is started and popped by a monitor on every oValid.
module tb_dedicated_countdown;
    import dedicated_pkg::*;

    localparam int WIDTH = 8;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic             iStart = 1'b0;
    logic [WIDTH-1:0] iLoadVal = '0;
    logic             iHold = 1'b0;
    logic [WIDTH-1:0] oOut;
    logic             oValid;
    logic             oBusy;
    logic             oDone;

    dedicated_countdown #(.WIDTH(WIDTH)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iLoadVal(iLoadVal),
        .iHold   (iHold),
        .oOut    (oOut),
        .oValid  (oValid),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int expQ[$];
    int validCyc[$];
    int doneCyc[$];
    int busyGaps = 0;
    bit inRun = 1'b0;
    int startAt;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Monitor: samples 1 ns after each rising edge.
    initial forever begin
        @(posedge iClk);
        #1;
        if (oDone) begin
            doneCyc.push_back(cyc);
            inRun = 1'b0;
        end else if (inRun && !oBusy) begin
            busyGaps++;
        end
        if (oValid) begin
            validCyc.push_back(cyc);
            if (expQ.size() == 0) check("unexpected_valid", int'(oOut), -1);
            else check("value", int'(oOut), expQ.pop_front());
        end
    end

    task automatic clearLogs();
        validCyc.delete();
        doneCyc.delete();
        busyGaps = 0;
    endtask

    task automatic pushSeq(input int n);
        for (int v = n; v >= 0; v--) expQ.push_back(v);
    endtask

    // One-cycle start pulse; startAt is the cycle number of the sampling edge.
    task automatic startPulse(input int n);
        @(negedge iClk);
        iLoadVal = WIDTH'(n);
        iStart   = 1'b1;
        inRun    = 1'b1;
        startAt  = cyc + 1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic waitValids(input int n, input int budget);
        int k = 0;
        while (validCyc.size() < n && k < budget) begin
            @(posedge iClk);
            #2;
            k++;
        end
        if (validCyc.size() < n) check("timeout_valids", validCyc.size(), n);
    endtask

    task automatic waitDones(input int n, input int budget);
        int k = 0;
        while (doneCyc.size() < n && k < budget) begin
            @(posedge iClk);
            #2;
            k++;
        end
        if (doneCyc.size() < n) check("timeout_done", doneCyc.size(), n);
    endtask

    // Valid 2 edges after the sampling edge (IDLE->LOAD->OUT->buffer),
    // 3 cycles per value, done 2 cycles after the last value.
    task automatic checkTiming(input int stretchIdx, input int stretch);
        if (validCyc.size() > 0) begin
            check("first_latency", validCyc[0] - startAt, 2);
            for (int i = 1; i < validCyc.size(); i++)
                check($sformatf("gap%0d", i), validCyc[i] - validCyc[i-1],
                      (i == stretchIdx) ? 3 + stretch : 3);
            if (doneCyc.size() > 0)
                check("done_latency", doneCyc[0] - validCyc[validCyc.size()-1], 2);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge iClk);
        check("rst_out", int'(oOut), 0);
        check("rst_valid", int'(oValid), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);

        // N=3 basic run
        clearLogs();
        pushSeq(3);
        startPulse(3);
        waitDones(1, 40);
        check("n3_count", validCyc.size(), 4);
        checkTiming(-1, 0);
        check("n3_busy_gaps", busyGaps, 0);
        check("n3_busy_at_done", int'(oBusy), 0);
        repeat (3) @(negedge iClk);
        check("n3_out_hold", int'(oOut), 0);
        check("n3_q_empty", expQ.size(), 0);

        // N=0: one value, no decrement
        clearLogs();
        pushSeq(0);
        startPulse(0);
        waitDones(1, 20);
        repeat (4) @(negedge iClk);
        check("n0_count", validCyc.size(), 1);
        checkTiming(-1, 0);
        check("n0_out_hold", int'(oOut), 0);
        check("n0_q_empty", expQ.size(), 0);

        // N=5 with a 4-cycle hold right after the value 4
        clearLogs();
        pushSeq(5);
        startPulse(5);
        waitValids(2, 20);
        @(negedge iClk);
        iHold = 1'b1;
        repeat (4) @(negedge iClk);
        iHold = 1'b0;
        waitDones(1, 60);
        check("hold_count", validCyc.size(), 6);
        checkTiming(2, 4);
        check("hold_busy_gaps", busyGaps, 0);
        check("hold_q_empty", expQ.size(), 0);

        // N=2 with an ignored start request while busy
        clearLogs();
        pushSeq(2);
        startPulse(2);
        repeat (2) @(negedge iClk);
        iLoadVal = 8'd9;
        iStart   = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        waitDones(1, 40);
        repeat (6) @(negedge iClk);
        check("busy_start_count", validCyc.size(), 3);
        check("busy_start_dones", doneCyc.size(), 1);
        checkTiming(-1, 0);
        check("busy_start_idle", int'(oBusy), 0);
        check("busy_start_q_empty", expQ.size(), 0);

        // N=255, asynchronous reset after the value 250
        clearLogs();
        pushSeq(255);
        startPulse(255);
        waitValids(6, 40);
        inRun = 1'b0;
        #1;
        iRst = 1'b1;
        #1;
        check("arst_out", int'(oOut), 0);
        check("arst_valid", int'(oValid), 0);
        check("arst_busy", int'(oBusy), 0);
        check("arst_done", int'(oDone), 0);
        check("arst_state", int'(dut.state), int'(S_IDLE));
        check("arst_count", validCyc.size(), 6);
        expQ.delete();
        @(negedge iClk);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
        clearLogs();
        pushSeq(1);
        startPulse(1);
        waitDones(1, 30);
        check("post_rst_count", validCyc.size(), 2);
        checkTiming(-1, 0);
        check("post_rst_q_empty", expQ.size(), 0);

        // iStart held high: back-to-back runs of N=1
        repeat (2) @(negedge iClk);
        clearLogs();
        pushSeq(1);
        pushSeq(1);
        @(negedge iClk);
        iLoadVal = 8'd1;
        iStart   = 1'b1;
        inRun    = 1'b1;
        startAt  = cyc + 1;
        waitDones(2, 60);
        iStart = 1'b0;
        repeat (6) @(negedge iClk);
        check("b2b_count", validCyc.size(), 4);
        check("b2b_dones", doneCyc.size(), 2);
        if (validCyc.size() == 4 && doneCyc.size() == 2) begin
            check("b2b_first", validCyc[0] - startAt, 2);
            check("b2b_gap1", validCyc[1] - validCyc[0], 3);
            check("b2b_done1", doneCyc[0] - validCyc[1], 2);
            check("b2b_restart", validCyc[2] - doneCyc[0], 3);
            check("b2b_gap3", validCyc[3] - validCyc[2], 3);
            check("b2b_done2", doneCyc[1] - validCyc[3], 2);
        end
        check("b2b_idle", int'(oBusy), 0);
        check("b2b_q_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
